// File: rtl/regfile_bypass_scoreboard_if.sv
// Register-file bus: ID read/issue signals, WB writeback, and the scoreboard busy flags.
// The master drives indices, writeback and issue; the slave (the register file) returns data and busy.
interface regfile_bypass_scoreboard_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32
);
    localparam int unsigned AW = $clog2(NREGS);

    logic            regwrite;
    logic [AW-1:0]   writereg;
    logic [XLEN-1:0] writedata;
    logic [AW-1:0]   readreg1;
    logic [AW-1:0]   readreg2;
    logic [XLEN-1:0] readdata1;
    logic [XLEN-1:0] readdata2;
    logic            issue_valid;
    logic [AW-1:0]   issue_rd;
    logic            flush;
    logic            busy1;
    logic            busy2;

    modport master (
        output regwrite, writereg, writedata, readreg1, readreg2,
        output issue_valid, issue_rd, flush,
        input  readdata1, readdata2, busy1, busy2
    );

    modport slave (
        input  regwrite, writereg, writedata, readreg1, readreg2,
        input  issue_valid, issue_rd, flush,
        output readdata1, readdata2, busy1, busy2
    );
endinterface

// File: rtl/regfile_bypass_scoreboard.sv
// General-purpose register file with two async read ports, one write port, write-through
// bypass and a per-register in-flight-producer scoreboard for the hazard unit.
module regfile_bypass_scoreboard #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    regfile_bypass_scoreboard_if.slave   bus
);
    localparam int unsigned AW = $clog2(NREGS);

    logic [XLEN-1:0]  r_regs [NREGS];
    logic [NREGS-1:0] r_busy;

    logic             w_wr_en;
    logic [NREGS-1:0] w_busy_next;

    assign w_wr_en = bus.regwrite && (bus.writereg != '0);

    // Order matters: flush clears, writeback retires, then a new issue sets (newest producer wins).
    always_comb begin
        w_busy_next = bus.flush ? '0 : r_busy;
        if (w_wr_en)
            w_busy_next[bus.writereg] = 1'b0;
        if (bus.issue_valid && (bus.issue_rd != '0))
            w_busy_next[bus.issue_rd] = 1'b1;
        w_busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREGS; i++)
                r_regs[i] <= '0;
            r_busy <= '0;
        end else begin
            if (w_wr_en)
                r_regs[bus.writereg] <= bus.writedata;
            r_busy <= w_busy_next;
        end
    end

    function automatic logic [XLEN-1:0] read_port(input logic [AW-1:0] idx);
        if (idx == '0)
            return '0;
        else if (bus.regwrite && (bus.writereg == idx))
            return bus.writedata;
        else
            return r_regs[idx];
    endfunction

    always_comb begin
        bus.readdata1 = read_port(bus.readreg1);
        bus.readdata2 = read_port(bus.readreg2);
        // A producer retiring this cycle is bypassed, so it does not stall the reader.
        bus.busy1     = r_busy[bus.readreg1] && !(w_wr_en && (bus.writereg == bus.readreg1));
        bus.busy2     = r_busy[bus.readreg2] && !(w_wr_en && (bus.writereg == bus.readreg2));
    end
endmodule

// File: tb/tb_regfile_bypass_scoreboard.sv
// Self-checking bench for regfile_bypass_scoreboard: directed scenarios plus randomized traffic
// checked against an array-based reference model of the register file and scoreboard.
module tb_regfile_bypass_scoreboard;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned NREGS = 32;

    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    regfile_bypass_scoreboard_if #(.XLEN(XLEN), .NREGS(NREGS)) rf ();

    regfile_bypass_scoreboard #(.XLEN(XLEN), .NREGS(NREGS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (rf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: plain arrays of register values and pending-producer flags.
    logic [XLEN-1:0] m_reg  [NREGS];
    bit              m_busy [NREGS];

    function automatic logic [XLEN-1:0] exp_data(input int idx);
        if (idx == 0) return '0;
        if (rf.regwrite && int'(rf.writereg) == idx) return rf.writedata;
        return m_reg[idx];
    endfunction

    function automatic logic exp_busy(input int idx);
        if (rf.regwrite && rf.writereg != 0 && int'(rf.writereg) == idx) return 1'b0;
        return m_busy[idx];
    endfunction

    task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_ports(input string tag);
        #1;
        chk({tag, ".rd1"},   rf.readdata1, exp_data(int'(rf.readreg1)));
        chk({tag, ".rd2"},   rf.readdata2, exp_data(int'(rf.readreg2)));
        chk({tag, ".busy1"}, {31'b0, rf.busy1}, {31'b0, exp_busy(int'(rf.readreg1))});
        chk({tag, ".busy2"}, {31'b0, rf.busy2}, {31'b0, exp_busy(int'(rf.readreg2))});
    endtask

    // Advance one clock edge and apply the same edge to the model.
    task automatic step();
        int wr, rd;
        @(posedge clk);
        wr = int'(rf.writereg);
        rd = int'(rf.issue_rd);
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                m_reg[i]  = '0;
                m_busy[i] = 1'b0;
            end
        end else begin
            if (rf.flush)
                for (int i = 0; i < NREGS; i++) m_busy[i] = 1'b0;
            if (rf.regwrite && wr != 0) begin
                m_reg[wr]  = rf.writedata;
                m_busy[wr] = 1'b0;
            end
            if (rf.issue_valid && rd != 0) m_busy[rd] = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic idle();
        rst            = 1'b0;
        rf.regwrite    = 1'b0;
        rf.writereg    = '0;
        rf.writedata   = '0;
        rf.issue_valid = 1'b0;
        rf.issue_rd    = '0;
        rf.flush       = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < NREGS; i++) begin
            m_reg[i]  = $urandom;
            m_busy[i] = 1'b1;
        end
        idle();
        rf.readreg1 = '0;
        rf.readreg2 = '0;

        // Garbage before reset.
        repeat (6) begin
            rf.regwrite    = 1'b1;
            rf.writereg    = 5'($urandom_range(1, NREGS - 1));
            rf.writedata   = $urandom;
            rf.issue_valid = 1'b1;
            rf.issue_rd    = 5'($urandom_range(1, NREGS - 1));
            @(negedge clk);
        end
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < NREGS; i++) begin
            rf.readreg1 = 5'(i);
            rf.readreg2 = 5'(NREGS - 1 - i);
            #1;
            chk("reset.rd1",   rf.readdata1, '0);
            chk("reset.rd2",   rf.readdata2, '0);
            chk("reset.busy1", {31'b0, rf.busy1}, '0);
            chk("reset.busy2", {31'b0, rf.busy2}, '0);
        end

        // Write-through bypass, then the stored value.
        rf.regwrite = 1'b1; rf.writereg = 5'd5; rf.writedata = 32'hDEADBEEF;
        rf.readreg1 = 5'd5; rf.readreg2 = 5'd0;
        #1 chk("bypass.same_cycle", rf.readdata1, 32'hDEADBEEF);
        step();
        idle();
        #1 chk("bypass.stored", rf.readdata1, 32'hDEADBEEF);

        // Register 0 is hardwired.
        rf.regwrite = 1'b1; rf.writereg = 5'd0; rf.writedata = 32'hFFFFFFFF;
        rf.issue_valid = 1'b1; rf.issue_rd = 5'd0;
        rf.readreg1 = 5'd0; rf.readreg2 = 5'd0;
        #1 chk("r0.bypass", rf.readdata1, '0);
        step();
        idle();
        #1 chk("r0.data", rf.readdata2, '0);
        chk("r0.busy", {31'b0, rf.busy2}, '0);

        // Issue then retire register 7.
        rf.issue_valid = 1'b1; rf.issue_rd = 5'd7; rf.readreg1 = 5'd7;
        #1 chk("sb.own_issue_invisible", {31'b0, rf.busy1}, '0);
        step();
        idle();
        #1 chk("sb.set7", {31'b0, rf.busy1}, 32'd1);
        rf.regwrite = 1'b1; rf.writereg = 5'd7; rf.writedata = 32'h0000_0777;
        #1 chk("sb.retire7_bypassed", {31'b0, rf.busy1}, '0);
        step();
        idle();
        #1 chk("sb.clear7", {31'b0, rf.busy1}, '0);
        chk("sb.data7", rf.readdata1, 32'h0000_0777);

        // Same-index set and clear: set wins, data still written.
        rf.issue_valid = 1'b1; rf.issue_rd = 5'd9;
        rf.regwrite = 1'b1; rf.writereg = 5'd9; rf.writedata = 32'h1234_5678;
        step();
        idle();
        rf.readreg1 = 5'd9;
        #1 chk("sb.set_wins9", {31'b0, rf.busy1}, 32'd1);
        chk("sb.data9", rf.readdata1, 32'h1234_5678);

        // Flush with concurrent issue keeps only the new producer.
        rf.regwrite = 1'b1; rf.writereg = 5'd4; rf.writedata = 32'hCAFE_0004; step(); idle();
        foreach (rf.issue_rd[b]) ;
        rf.issue_valid = 1'b1;
        rf.issue_rd = 5'd3; step();
        rf.issue_rd = 5'd4; step();
        rf.issue_rd = 5'd6; step();
        idle();
        rf.readreg1 = 5'd3; rf.readreg2 = 5'd6;
        #1 chk("fl.pre3", {31'b0, rf.busy1}, 32'd1);
        chk("fl.pre6", {31'b0, rf.busy2}, 32'd1);
        rf.flush = 1'b1; rf.issue_valid = 1'b1; rf.issue_rd = 5'd4;
        step();
        idle();
        for (int i = 1; i < NREGS; i++) begin
            rf.readreg1 = 5'(i);
            #1 chk("fl.after", {31'b0, rf.busy1}, (i == 4) ? 32'd1 : 32'd0);
        end

        // Reset overrides a same-cycle write.
        rst = 1'b1; rf.regwrite = 1'b1; rf.writereg = 5'd4; rf.writedata = 32'hBAD0_0004;
        step();
        idle();
        rf.readreg1 = 5'd4;
        #1 chk("rst.data4", rf.readdata1, '0);
        chk("rst.busy4", {31'b0, rf.busy1}, '0);

        // Randomized traffic, concentrated on a few indices to provoke hazards.
        for (int n = 0; n < 400; n++) begin
            rst            = ($urandom_range(0, 99) == 0);
            rf.regwrite    = $urandom_range(0, 1) == 1;
            rf.writereg    = 5'($urandom_range(0, 7));
            rf.writedata   = $urandom;
            rf.issue_valid = $urandom_range(0, 2) != 0;
            rf.issue_rd    = 5'($urandom_range(0, 7));
            rf.flush       = ($urandom_range(0, 19) == 0);
            rf.readreg1    = 5'($urandom_range(0, 7));
            rf.readreg2    = ($urandom_range(0, 3) == 0) ? rf.writereg : 5'($urandom_range(0, NREGS - 1));
            check_ports("rand");
            step();
        end
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
